// File: rtl/mips_core_pkg.sv
// Shared types and sizing helpers for the memory-stage dispatch scheduler.
package mips_core_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_action_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

    localparam int LQ_DEPTH_DEF   = 8;
    localparam int SQ_DEPTH_DEF   = 8;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int BURST_MAX_DEF  = 4;

    function automatic int idx_w(input int a, input int b);
        return $clog2(a > b ? a : b);
    endfunction

endpackage

// File: rtl/mem_dispatch_scheduler_if.sv
// D-cache control bundle between the scheduler and the memory-stage glue.
interface mem_dispatch_scheduler_if #(
    parameter int LQ_DEPTH = 8,
    parameter int SQ_DEPTH = 8
);
    import mips_core_pkg::*;

    localparam int IW = idx_w(LQ_DEPTH, SQ_DEPTH);
    localparam int SW = $clog2(SQ_DEPTH);

    logic              dc_valid;
    mem_action_t       dc_mem_action;
    logic [IW-1:0]     dc_dispatch_index;
    logic              dc_bypass_possible;
    logic [SW-1:0]     dc_bypass_index;
    logic              dc_nop;
    logic              dc_resp_valid;

    modport master (
        output dc_valid, dc_mem_action, dc_dispatch_index,
        output dc_bypass_possible, dc_bypass_index, dc_nop,
        input  dc_resp_valid
    );

    modport slave (
        input  dc_valid, dc_mem_action, dc_dispatch_index,
        input  dc_bypass_possible, dc_bypass_index, dc_nop,
        output dc_resp_valid
    );

endinterface

// File: rtl/mem_dispatch_scheduler_bypass.sv
// Per-load search for the youngest older store to the same word.
module mem_bypass_finder #(
    parameter int SQ_DEPTH = 8,
    parameter int WORD_W   = 30
) (
    input  logic                         ready,
    input  logic [WORD_W-1:0]            word,
    input  logic [SQ_DEPTH-1:0]          older,
    input  logic [SQ_DEPTH-1:0]          sq_valid,
    input  logic [SQ_DEPTH-1:0]          sq_data_valid,
    input  logic [SQ_DEPTH*WORD_W-1:0]   sq_word,
    input  logic [$clog2(SQ_DEPTH)-1:0]  sq_head,
    output logic                         eligible,
    output logic                         bypass,
    output logic [$clog2(SQ_DEPTH)-1:0]  bypass_index
);
    localparam int SW = $clog2(SQ_DEPTH);

    logic          hit;
    logic [SW-1:0] age;
    logic [SW-1:0] age_best;
    logic [SW-1:0] best;

    // Age relative to sq_head orders the circular store queue.
    always_comb begin
        hit      = 1'b0;
        age      = '0;
        age_best = '0;
        best     = '0;
        for (int s = 0; s < SQ_DEPTH; s++) begin
            age = SW'(s) - sq_head;
            if (older[s] && sq_valid[s] &&
                sq_word[s*WORD_W +: WORD_W] == word) begin
                if (!hit || age > age_best) begin
                    hit      = 1'b1;
                    age_best = age;
                    best     = SW'(s);
                end
            end
        end
        bypass       = hit;
        bypass_index = best;
        eligible     = ready && (!hit || sq_data_valid[best]);
    end

endmodule

// File: rtl/mem_dispatch_scheduler.sv
// Memory-stage scheduler: picks a load or committed store and drives
// the d-cache bundle until the transaction completes.
module mem_dispatch_scheduler
    import mips_core_pkg::*;
#(
    parameter int LQ_DEPTH        = LQ_DEPTH_DEF,
    parameter int SQ_DEPTH        = SQ_DEPTH_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int STORE_BURST_MAX = BURST_MAX_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [LQ_DEPTH-1:0]             lq_ready,
    input  logic [LQ_DEPTH*ADDR_WIDTH-1:0]  lq_addr,
    input  logic [LQ_DEPTH*SQ_DEPTH-1:0]    lq_older_sq,
    input  logic [$clog2(LQ_DEPTH)-1:0]     lq_head,
    input  logic [SQ_DEPTH-1:0]             sq_valid,
    input  logic [SQ_DEPTH*ADDR_WIDTH-1:0]  sq_addr,
    input  logic [SQ_DEPTH-1:0]             sq_data_valid,
    input  logic [$clog2(SQ_DEPTH)-1:0]     sq_head,
    input  logic                            sq_head_committed,
    input  logic                            flush,
    mem_dispatch_scheduler_if.master        dc,
    output logic                            load_done,
    output logic                            store_done
);
    localparam int LW   = $clog2(LQ_DEPTH);
    localparam int SW   = $clog2(SQ_DEPTH);
    localparam int IW   = idx_w(LQ_DEPTH, SQ_DEPTH);
    localparam int WW   = ADDR_WIDTH - 2;
    localparam int CW   = $clog2(STORE_BURST_MAX + 1);
    localparam logic [CW-1:0] CMAX = CW'(STORE_BURST_MAX);

    logic [SQ_DEPTH*WW-1:0] sq_word;
    logic [LQ_DEPTH-1:0]    ld_elig;
    logic [LQ_DEPTH-1:0]    ld_byp;
    logic [SW-1:0]          ld_bidx [LQ_DEPTH];
    logic [1:0]             unused_lo;

    for (genvar s = 0; s < SQ_DEPTH; s++) begin : g_sq
        assign sq_word[s*WW +: WW] = sq_addr[s*ADDR_WIDTH+2 +: WW];
    end

    for (genvar i = 0; i < LQ_DEPTH; i++) begin : g_ld
        mem_bypass_finder #(
            .SQ_DEPTH (SQ_DEPTH),
            .WORD_W   (WW)
        ) u_find (
            .ready         (lq_ready[i]),
            .word          (lq_addr[i*ADDR_WIDTH+2 +: WW]),
            .older         (lq_older_sq[i*SQ_DEPTH +: SQ_DEPTH]),
            .sq_valid      (sq_valid),
            .sq_data_valid (sq_data_valid),
            .sq_word       (sq_word),
            .sq_head       (sq_head),
            .eligible      (ld_elig[i]),
            .bypass        (ld_byp[i]),
            .bypass_index  (ld_bidx[i])
        );
    end

    // Byte offsets never participate in word matching.
    always_comb begin
        unused_lo = '0;
        for (int s = 0; s < SQ_DEPTH; s++)
            unused_lo ^= sq_addr[s*ADDR_WIDTH +: 2];
        for (int i = 0; i < LQ_DEPTH; i++)
            unused_lo ^= lq_addr[i*ADDR_WIDTH +: 2];
    end

    logic          ld_any;
    logic [LW-1:0] ld_pick;
    logic [LW-1:0] cand;
    logic          st_elig;

    always_comb begin
        ld_any  = 1'b0;
        ld_pick = '0;
        cand    = '0;
        for (int k = 0; k < LQ_DEPTH; k++) begin
            cand = lq_head + LW'(k);
            if (!ld_any && ld_elig[cand]) begin
                ld_any  = 1'b1;
                ld_pick = cand;
            end
        end
    end

    assign st_elig = sq_head_committed && sq_valid[sq_head];

    sched_state_t  state_q, state_d;
    mem_action_t   act_q, act_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          byp_q, byp_d;
    logic [SW-1:0] bidx_q, bidx_d;
    logic          nop_q, nop_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            act_q   <= READ;
            idx_q   <= '0;
            byp_q   <= 1'b0;
            bidx_q  <= '0;
            nop_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            idx_q   <= idx_d;
            byp_q   <= byp_d;
            bidx_q  <= bidx_d;
            nop_q   <= nop_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        idx_d      = idx_q;
        byp_d      = byp_q;
        bidx_d     = bidx_q;
        nop_d      = nop_q;
        cnt_d      = cnt_q;
        load_done  = 1'b0;
        store_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!flush) begin
                    // Stores win until a waiting load has been passed over enough times.
                    if (st_elig && !(cnt_q == CMAX && ld_any)) begin
                        state_d = BUSY;
                        act_d   = WRITE;
                        idx_d   = IW'(sq_head);
                        byp_d   = 1'b0;
                        bidx_d  = '0;
                        nop_d   = 1'b0;
                        if (ld_any && cnt_q != CMAX)
                            cnt_d = cnt_q + 1'b1;
                    end else if (ld_any) begin
                        state_d = BUSY;
                        act_d   = READ;
                        idx_d   = IW'(ld_pick);
                        byp_d   = ld_byp[ld_pick];
                        bidx_d  = ld_byp[ld_pick] ? ld_bidx[ld_pick] : '0;
                        nop_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                if (act_q == WRITE) begin
                    if (dc.dc_resp_valid) begin
                        store_done = 1'b1;
                        state_d    = IDLE;
                    end
                end else if (byp_q || dc.dc_resp_valid) begin
                    load_done = 1'b1;
                    state_d   = IDLE;
                    nop_d     = 1'b0;
                end else if (flush) begin
                    nop_d = 1'b1;
                end
            end
        endcase
    end

    logic busy;
    assign busy = (state_q == BUSY);

    assign dc.dc_valid           = busy;
    assign dc.dc_mem_action      = busy ? act_q : READ;
    assign dc.dc_dispatch_index  = busy ? idx_q : '0;
    assign dc.dc_bypass_possible = busy && byp_q;
    assign dc.dc_bypass_index    = busy ? bidx_q : '0;
    assign dc.dc_nop             = busy && nop_q;

endmodule
